id_ex_stage: RTL and testbench

Pipeline register and operand-select stage between instruction decode and the EX-stage ALU. It latches decoded operands and control on each clock and drives the ALU opcode and both 32-bit ALU operands. Operands are resolved each cycle by forwarding from the MEM and WB stages. The block also detects load-use hazards, raises a stall to the front end, and inserts a bubble on stall or flush.

---
 rtl/id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use
// hazard detection.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   D*                  decoded instruction fields from the ID stage
//   FLUSH               squash the decoded instruction (taken branch/jump)
//   MWREG/MRN/MALU      MEM-stage writeback (forward source, highest priority)
//   WWREG/WRN/WDATA     WB-stage writeback (forward source)
//   STALL               hold PC and IF/ID for one cycle on a load-use hazard
//   EALUC, EXA, EXB     ALU opcode and operands
//   ESTD                forwarded rt value used as store data
//   ERN, EWREG, EM2REG, EWMEM  EX-stage destination and control
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      DALUC,
  input  logic [XLEN-1:0] DA,
  input  logic [XLEN-1:0] DB,
  input  logic [XLEN-1:0] DIMM,
  input  logic [XLEN-1:0] DPC8,
  input  logic [RW-1:0]   DRS,
  input  logic [RW-1:0]   DRT,
  input  logic [RW-1:0]   DRN,
  input  logic            DUSERS,
  input  logic            DUSERT,
  input  logic            DALUIMM,
  input  logic            DJAL,
  input  logic            DWREG,
  input  logic            DM2REG,
  input  logic            DWMEM,
  input  logic            FLUSH,
  input  logic            MWREG,
  input  logic [RW-1:0]   MRN,
  input  logic [XLEN-1:0] MALU,
  input  logic            WWREG,
  input  logic [RW-1:0]   WRN,
  input  logic [XLEN-1:0] WDATA,
  output logic            STALL,
  output logic [3:0]      EALUC,
  output logic [XLEN-1:0] EXA,
  output logic [XLEN-1:0] EXB,
  output logic [XLEN-1:0] ESTD,
  output logic [RW-1:0]   ERN,
  output logic            EWREG,
  output logic            EM2REG,
  output logic            EWMEM
);

  localparam logic [3:0] ALUC_ADD = 4'b0010;

  logic [3:0]      aluc_q, aluc_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, pc8_q, pc8_d;
  logic [RW-1:0]   rs_q, rs_d, rt_q, rt_d, rn_q, rn_d;
  logic            users_q, users_d, usert_q, usert_d;
  logic            aluimm_q, aluimm_d, jal_q, jal_d;
  logic            wreg_q, wreg_d, m2reg_q, m2reg_d, wmem_q, wmem_d;

  logic            stall_c;
  logic [XLEN-1:0] fa, fb;

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    stall_c = m2reg_q & (rn_q != '0) &
              ((DUSERS & (DRS == rn_q)) | (DUSERT & (DRT == rn_q)));
  end

  // Bubble on stall or flush, otherwise capture the decoded instruction.
  always_comb begin
    aluc_d   = ALUC_ADD;
    a_d      = '0;
    b_d      = '0;
    imm_d    = '0;
    pc8_d    = '0;
    rs_d     = '0;
    rt_d     = '0;
    rn_d     = '0;
    users_d  = 1'b0;
    usert_d  = 1'b0;
    aluimm_d = 1'b0;
    jal_d    = 1'b0;
    wreg_d   = 1'b0;
    m2reg_d  = 1'b0;
    wmem_d   = 1'b0;
    if (!(stall_c || FLUSH)) begin
      aluc_d   = DALUC;
      a_d      = DA;
      b_d      = DB;
      imm_d    = DIMM;
      pc8_d    = DPC8;
      rs_d     = DRS;
      rt_d     = DRT;
      rn_d     = DRN;
      users_d  = DUSERS;
      usert_d  = DUSERT;
      aluimm_d = DALUIMM;
      jal_d    = DJAL;
      wreg_d   = DWREG;
      m2reg_d  = DM2REG;
      wmem_d   = DWMEM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluc_q   <= ALUC_ADD;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      pc8_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rn_q     <= '0;
      users_q  <= 1'b0;
      usert_q  <= 1'b0;
      aluimm_q <= 1'b0;
      jal_q    <= 1'b0;
      wreg_q   <= 1'b0;
      m2reg_q  <= 1'b0;
      wmem_q   <= 1'b0;
    end else begin
      aluc_q   <= aluc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      pc8_q    <= pc8_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rn_q     <= rn_d;
      users_q  <= users_d;
      usert_q  <= usert_d;
      aluimm_q <= aluimm_d;
      jal_q    <= jal_d;
      wreg_q   <= wreg_d;
      m2reg_q  <= m2reg_d;
      wmem_q   <= wmem_d;
    end
  end

  // Forwarding: MEM (youngest) beats WB; register 0 is never forwarded.
  always_comb begin
    if (MWREG && (MRN != '0) && (MRN == rs_q))      fa = MALU;
    else if (WWREG && (WRN != '0) && (WRN == rs_q)) fa = WDATA;
    else                                            fa = a_q;

    if (MWREG && (MRN != '0) && (MRN == rt_q))      fb = MALU;
    else if (WWREG && (WRN != '0) && (WRN == rt_q)) fb = WDATA;
    else                                            fb = b_q;
  end

  always_comb begin
    STALL  = stall_c;
    EALUC  = aluc_q;
    EXA    = jal_q ? pc8_q : fa;
    EXB    = aluimm_q ? imm_q : fb;
    ESTD   = fb;
    ERN    = rn_q;
    EWREG  = wreg_q;
    EM2REG = m2reg_q;
    EWMEM  = wmem_q;
  end

  // Source-register usage flags are kept in EX state for completeness; the
  // forwarding rule itself keys only on RS/RT.
  logic unused_use;
  assign unused_use = users_q ^ usert_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk, rst;
  logic [3:0]  DALUC;
  logic [31:0] DA, DB, DIMM, DPC8;
  logic [4:0]  DRS, DRT, DRN;
  logic        DUSERS, DUSERT, DALUIMM, DJAL, DWREG, DM2REG, DWMEM, FLUSH;
  logic        MWREG, WWREG;
  logic [4:0]  MRN, WRN;
  logic [31:0] MALU, WDATA;
  logic        STALL, EWREG, EM2REG, EWMEM;
  logic [3:0]  EALUC;
  logic [31:0] EXA, EXB, ESTD;
  logic [4:0]  ERN;

  id_ex_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .DALUC(DALUC), .DA(DA), .DB(DB), .DIMM(DIMM),
    .DPC8(DPC8), .DRS(DRS), .DRT(DRT), .DRN(DRN), .DUSERS(DUSERS),
    .DUSERT(DUSERT), .DALUIMM(DALUIMM), .DJAL(DJAL), .DWREG(DWREG),
    .DM2REG(DM2REG), .DWMEM(DWMEM), .FLUSH(FLUSH), .MWREG(MWREG), .MRN(MRN),
    .MALU(MALU), .WWREG(WWREG), .WRN(WRN), .WDATA(WDATA), .STALL(STALL),
    .EALUC(EALUC), .EXA(EXA), .EXB(EXB), .ESTD(ESTD), .ERN(ERN),
    .EWREG(EWREG), .EM2REG(EM2REG), .EWMEM(EWMEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, aluc, exa, exb, estd, rn, wreg, m2reg, wmem}
  typedef struct packed {
    logic        stall;
    logic [3:0]  aluc;
    logic [31:0] exa, exb, estd;
    logic [4:0]  rn;
    logic        wreg, m2reg, wmem;
  } obs_t;

  obs_t sb[$];
  obs_t obs, exp_v;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t sample();
    return {STALL, EALUC, EXA, EXB, ESTD, ERN, EWREG, EM2REG, EWMEM};
  endfunction

  function automatic obs_t mk(input logic st, input logic [3:0] al,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] s, input logic [4:0] rn,
                              input logic w, input logic m, input logic wm);
    return {st, al, a, b, s, rn, w, m, wm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    DALUC = 4'd0; DA = '0; DB = '0; DIMM = '0; DPC8 = '0;
    DRS = '0; DRT = '0; DRN = '0; DUSERS = 0; DUSERT = 0; DALUIMM = 0;
    DJAL = 0; DWREG = 0; DM2REG = 0; DWMEM = 0; FLUSH = 0;
    MWREG = 0; MRN = '0; MALU = '0; WWREG = 0; WRN = '0; WDATA = '0;
  endtask

  task automatic load_r4();
    idle();
    DALUC = 4'b0010; DRN = 5'd4; DWREG = 1; DM2REG = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    DALUC = 4'b0110; DA = 32'h11; DB = 32'h22; DRN = 5'd9; DWREG = 1; DWMEM = 1;
    sb.push_back(mk(0, 4'b0110, 32'h11, 32'h22, 32'h22, 5'd9, 1, 0, 1));
    tick();
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_pre: got %h want %h", obs, exp_v); end
    #2 rst = 1'b1;
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 0, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_async: got %h want %h", obs, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_capture();
    idle();
    DALUC = 4'b0010; DA = 32'd5; DB = 32'd7; DRS = 5'd1; DRT = 5'd2;
    DRN = 5'd8; DUSERS = 1; DUSERT = 1; DWREG = 1;
    sb.push_back(mk(0, 4'b0010, 32'd5, 32'd7, 32'd7, 5'd8, 1, 0, 0));
    tick();
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL capture: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_forward();
    idle();
    DALUC = 4'b0110; DA = 32'h11; DB = 32'h22; DRS = 5'd3; DRT = 5'd6;
    DRN = 5'd7; DUSERS = 1; DUSERT = 1; DWREG = 1;
    tick();
    idle();
    MWREG = 1; MRN = 5'd3; MALU = 32'hAA; WWREG = 1; WRN = 5'd3; WDATA = 32'hBB;
    sb.push_back(mk(0, 4'b0110, 32'hAA, 32'h22, 32'h22, 5'd7, 1, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL fwd_mem_wins: got %h want %h", obs, exp_v); end
    MWREG = 0;
    sb.push_back(mk(0, 4'b0110, 32'hBB, 32'h22, 32'h22, 5'd7, 1, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL fwd_wb: got %h want %h", obs, exp_v); end
    // WB forward on rt while MEM targets a different register
    MWREG = 1; MRN = 5'd12; WRN = 5'd6;
    sb.push_back(mk(0, 4'b0110, 32'h11, 32'hBB, 32'hBB, 5'd7, 1, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL fwd_wb_rt: got %h want %h", obs, exp_v); end
    // register 0 never forwarded
    idle();
    DALUC = 4'b0010; DA = 32'h33; DB = 32'h44; DRN = 5'd2; DWREG = 1;
    tick();
    MWREG = 1; MRN = 5'd0; MALU = 32'hAA; WWREG = 1; WRN = 5'd0; WDATA = 32'hBB;
    sb.push_back(mk(0, 4'b0010, 32'h33, 32'h44, 32'h44, 5'd2, 1, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL fwd_r0: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_load_use();
    load_r4();
    idle();
    DALUC = 4'b0010; DA = 32'h50; DB = 32'h60; DRS = 5'd4; DRT = 5'd1;
    DRN = 5'd5; DUSERS = 1; DUSERT = 1; DWREG = 1;
    sb.push_back(mk(1, 4'b0010, 0, 0, 0, 5'd4, 1, 1, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_stall: got %h want %h", obs, exp_v); end
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 5'd0, 0, 0, 0));
    tick();
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_bubble: got %h want %h", obs, exp_v); end
    sb.push_back(mk(0, 4'b0010, 32'h50, 32'h60, 32'h60, 5'd5, 1, 0, 0));
    tick();
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_reissue: got %h want %h", obs, exp_v); end
    // same registers but neither source is read: no hazard
    load_r4();
    DRS = 5'd4; DRT = 5'd4; DUSERS = 0; DUSERT = 0;
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 5'd4, 1, 1, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_unused: got %h want %h", obs, exp_v); end
    // rt-only hazard
    DUSERT = 1;
    sb.push_back(mk(1, 4'b0010, 0, 0, 0, 5'd4, 1, 1, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_rt: got %h want %h", obs, exp_v); end
    // reset during a stall clears state and STALL immediately
    rst = 1'b1;
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 5'd0, 0, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL lu_reset: got %h want %h", obs, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_imm_jal();
    idle();
    DALUC = 4'b1000; DA = 32'h7; DB = 32'h99; DIMM = 32'h0000_0140; DRT = 5'd2;
    DRN = 5'd3; DUSERT = 1; DALUIMM = 1; DWREG = 1;
    sb.push_back(mk(0, 4'b1000, 32'h7, 32'h140, 32'h99, 5'd3, 1, 0, 0));
    tick();
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL imm_shift: got %h want %h", obs, exp_v); end
    idle();
    DALUC = 4'b0100; DA = 32'h1234; DPC8 = 32'h0040_0010; DRS = 5'd3;
    DRN = 5'd31; DJAL = 1; DWREG = 1;
    tick();
    MWREG = 1; MRN = 5'd3; MALU = 32'hAA;
    sb.push_back(mk(0, 4'b0100, 32'h0040_0010, 0, 0, 5'd31, 1, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL jal_pc8: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_flush_store();
    idle();
    DALUC = 4'b0010; DA = 32'h100; DB = 32'h12; DIMM = 32'h10; DRS = 5'd2;
    DRT = 5'd9; DUSERS = 1; DUSERT = 1; DALUIMM = 1; DWMEM = 1; FLUSH = 1;
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 5'd0, 0, 0, 0));
    tick();
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL flush: got %h want %h", obs, exp_v); end
    FLUSH = 0;
    tick();
    WWREG = 1; WRN = 5'd9; WDATA = 32'hCAFE;
    sb.push_back(mk(0, 4'b0010, 32'h100, 32'h10, 32'hCAFE, 5'd0, 0, 0, 1));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL store_fwd: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    idle();
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom;
      DALUC = 4'(i + 3); DA = a; DB = b; DRS = 5'(i + 1); DRT = 5'(i + 2);
      DRN = 5'(i + 10); DWREG = 1'(i % 2);
      sb.push_back(mk(0, 4'(i + 3), a, b, b, 5'(i + 10), 1'(i % 2), 0, 0));
      tick();
      obs = sample(); exp_v = sb.pop_front(); n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", i, obs, exp_v); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 5'd0, 0, 0, 0));
    #1;
    obs = sample(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_init: got %h want %h", obs, exp_v); end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_capture();
    test_forward();
    test_load_use();
    test_imm_jal();
    test_flush_store();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
